// File: rtl/priority_scan_encoder_if.sv
// Handshake and status bundle between a request source / consumer and the
// priority scan encoder. The source side uses the master modport, the
// encoder uses the slave modport.
interface priority_scan_encoder_if #(
    parameter int WIDTH = 8
);
    localparam int CODE_W = $clog2(WIDTH);

    logic              load;
    logic [WIDTH-1:0]  data;
    logic              out_ready;
    logic [CODE_W-1:0] code;
    logic              out_valid;
    logic              busy;
    logic [WIDTH-1:0]  pending;
    logic              empty_load;
    logic              drop;

    modport master (
        output load, data, out_ready,
        input  code, out_valid, busy, pending, empty_load, drop
    );

    modport slave (
        input  load, data, out_ready,
        output code, out_valid, busy, pending, empty_load, drop
    );
endinterface

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: captures a request vector and hands out the
// index of each set bit, one per valid/ready transfer, in priority order.
//
// state | meaning
// IDLE  | no pending bits; a load with non-zero data starts a scan
// SCAN  | pending holds unserviced bits; code/out_valid present the next one
module priority_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    priority_scan_encoder_if.slave bus
);
    localparam int CODE_W = $clog2(WIDTH);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic              empty_load_q, empty_load_d;
    logic              drop_q, drop_d;
    logic [CODE_W-1:0] code_int;
    logic [WIDTH-1:0]  clear_mask;

    // Priority index of the registered pending vector; later loop hits win,
    // so loop direction selects highest-first or lowest-first.
    always_comb begin
        code_int = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending_q[i]) code_int = CODE_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) code_int = CODE_W'(i);
            end
        end
    end

    assign clear_mask = WIDTH'(1) << code_int;

    // Next-state, next-pending and one-cycle status pulses.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        empty_load_d = 1'b0;
        drop_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    if (bus.data != '0) begin
                        pending_d = bus.data;
                        state_d   = SCAN;
                    end else begin
                        empty_load_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                // Loads during a scan, even on the final transfer, are discarded.
                drop_d = bus.load;
                if (bus.out_ready) begin
                    pending_d = pending_q & ~clear_mask;
                    if (pending_d == '0) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State and status registers; reset drops any partial scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            empty_load_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            empty_load_q <= empty_load_d;
            drop_q       <= drop_d;
        end
    end

    // All outputs decode registered state only.
    assign bus.out_valid  = (state_q == SCAN);
    assign bus.busy       = (state_q == SCAN);
    assign bus.code       = (state_q == SCAN) ? code_int : '0;
    assign bus.pending    = pending_q;
    assign bus.empty_load = empty_load_q;
    assign bus.drop       = drop_q;
endmodule

// File: tb/tb_priority_scan_encoder.sv
// Bench for priority_scan_encoder: one highest-first and one lowest-first
// instance driven with identical stimulus, each compared every cycle against
// a queue of the codes still owed for the current vector.
module tb_priority_scan_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    int   qm[$];
    int   ql[$];
    logic exp_drop  = 1'b0;
    logic exp_empty = 1'b0;

    priority_scan_encoder_if #(.WIDTH(8)) bus_m ();
    priority_scan_encoder_if #(.WIDTH(8)) bus_l ();

    priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .bus(bus_m.slave));
    priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bus(bus_l.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mask_of(input int q[$]);
        logic [7:0] m = '0;
        foreach (q[k]) m[q[k]] = 1'b1;
        return m;
    endfunction

    task automatic check_all();
        chk("m_valid",   16'(bus_m.out_valid),  16'(qm.size() > 0));
        chk("m_busy",    16'(bus_m.busy),       16'(qm.size() > 0));
        chk("m_code",    16'(bus_m.code),       16'((qm.size() > 0) ? qm[0] : 0));
        chk("m_pending", 16'(bus_m.pending),    16'(mask_of(qm)));
        chk("m_drop",    16'(bus_m.drop),       16'(exp_drop));
        chk("m_empty",   16'(bus_m.empty_load), 16'(exp_empty));
        chk("l_valid",   16'(bus_l.out_valid),  16'(ql.size() > 0));
        chk("l_code",    16'(bus_l.code),       16'((ql.size() > 0) ? ql[0] : 0));
        chk("l_pending", 16'(bus_l.pending),    16'(mask_of(ql)));
        chk("l_drop",    16'(bus_l.drop),       16'(exp_drop));
        chk("l_empty",   16'(bus_l.empty_load), 16'(exp_empty));
    endtask

    // One clock: drive at negedge, advance the model at posedge, check at next negedge.
    task automatic step(input logic ld, input logic [7:0] dat, input logic rdy);
        logic busy_now;
        bus_m.load = ld; bus_m.data = dat; bus_m.out_ready = rdy;
        bus_l.load = ld; bus_l.data = dat; bus_l.out_ready = rdy;
        @(posedge clk);
        busy_now  = (qm.size() > 0);
        exp_drop  = ld && busy_now;
        exp_empty = ld && !busy_now && (dat == 8'h00);
        if (busy_now) begin
            if (rdy) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
        end else if (ld && dat != 8'h00) begin
            for (int i = 7; i >= 0; i--) if (dat[i]) qm.push_back(i);
            for (int i = 0; i < 8; i++)  if (dat[i]) ql.push_back(i);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bus_m.load = 1'b0; bus_m.data = '0; bus_m.out_ready = 1'b0;
        bus_l.load = 1'b0; bus_l.data = '0; bus_l.out_ready = 1'b0;
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);

        // Two bits, always ready: 2 then 0, then idle.
        step(1'b1, 8'h05, 1'b1);
        chk("t1_first_code", 16'(bus_m.code), 16'd2);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_second_code", 16'(bus_m.code), 16'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_idle_busy", 16'(bus_m.busy), 16'd0);
        step(1'b0, 8'h00, 1'b1);

        // All ones with stalls every other cycle.
        step(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, (i % 2 == 0));
        step(1'b0, 8'h00, 1'b1);

        // Lowest-first patterns (both instances see them).
        step(1'b1, 8'h7B, 1'b0);
        chk("t3_lsb_first", 16'(bus_l.code), 16'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h80, 1'b0);
        chk("t3_single", 16'(bus_l.code), 16'd7);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Empty load in idle.
        step(1'b1, 8'h00, 1'b1);
        chk("t4_empty_pulse", 16'(bus_m.empty_load), 16'd1);
        step(1'b0, 8'h00, 1'b1);

        // Load while busy is dropped, including on the final transfer.
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'hFF, 1'b1);
        chk("t5_drop_pulse", 16'(bus_m.drop), 16'd1);
        step(1'b1, 8'hFF, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h0C, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Reset mid-scan: immediate clear, nothing resumes after release.
        step(1'b1, 8'hF0, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        qm.delete(); ql.delete(); exp_drop = 1'b0; exp_empty = 1'b0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step(($urandom_range(0, 3) == 0), d, ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
Parametrised, sequential successor to the 8-to-3 combinational priority encoder. It captures a WIDTH-bit request vector and emits the index of every set bit, one per handshake, in priority order. Each emitted bit is cleared until the vector is exhausted. It sits between request-collection logic and a single-issue consumer such as an interrupt dispatcher or a one-at-a-time service unit.

Parameters:
WIDTH, 8, request vector width; legal range 2..256.
CODE_W, $clog2(WIDTH), code output width; derived, not overridden.
LSB_FIRST, 0, priority direction: 0 = highest set index wins, 1 = lowest set index wins.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
load  input  1  capture data this cycle; honoured only in IDLE.
data  input  WIDTH  request vector sampled when load=1.
out_ready  input  1  consumer accepts current code.
code  output  CODE_W  index of the current highest-priority pending bit.
out_valid  output  1  code is valid.
busy  output  1  block is in SCAN; new loads are dropped.
pending  output  WIDTH  remaining unserviced request bits (registered).
empty_load  output  1  one-cycle pulse: a load in IDLE carried data==0.
drop  output  1  one-cycle pulse: load asserted while busy, request discarded.

Behaviour:
- Reset (async, rst=1): state=IDLE, pending=0, code=0, out_valid=0, busy=0, empty_load=0, drop=0. No outputs glitch high during or after release.
- State machine has two states, IDLE and SCAN.
- IDLE, load=1, data!=0: pending<=data, state<=SCAN at that edge. out_valid=1 and busy=1 from the following cycle, so latency is 1 clock from load to first code.
- IDLE, load=1, data==0: state stays IDLE, pending stays 0, empty_load=1 for exactly the next cycle.
- IDLE, load=0: hold.
- SCAN:
  - out_valid=1 and busy=1.
  - code is the priority index of pending: the highest set index if LSB_FIRST=0, the lowest if LSB_FIRST=1.
  - code is a pure function of the registered pending; no combinational path from inputs to outputs.
  - code holds stable while out_ready=0.
- Handshake: a transfer occurs on a rising edge with out_valid=1 and out_ready=1.
  - On a transfer, pending[code] is cleared.
  - If the new pending==0, state<=IDLE, and out_valid and busy go low the next cycle. Otherwise the next code appears the next cycle.
  - At most one code transfers per clock.
- load=1 while in SCAN (including the cycle of the final transfer): ignored, drop=1 for the next cycle, pending and sequence unaffected. Loads are never queued.
- A new load is accepted no earlier than the first IDLE cycle after the final transfer. Back-to-back vectors therefore have a one-cycle gap.
- out_ready while out_valid=0 has no effect.
- In IDLE, code=0.
- Reset asserted mid-scan: immediate return to reset values. The remaining pending bits are lost and no partial code is presented after release.
- Number of transfers per vector equals popcount(data). The codes are all distinct and strictly monotonic in priority direction.
- Non-power-of-2 WIDTH: codes never exceed WIDTH-1. Unused code values never appear.

Test Plan:
1. WIDTH=8, LSB_FIRST=0, out_ready=1: load 8'b00000101 -> code=2 then code=0 on consecutive cycles. Then out_valid=0, busy=0, pending=0.
2. load 8'b11111111, out_ready toggled 1,0,1,0…: codes 7,6,5,4,3,2,1,0, each held stable during stall cycles. Exactly 8 transfers.
3. LSB_FIRST=1 instance: load 8'b01111011 -> codes 0,1,3,4,5,6. load 8'b10000000 -> single code 7.
4. IDLE load 8'b00000000 -> empty_load pulses for 1 cycle, busy stays 0, out_valid stays 0.
5. load 8'b01000001, then load 8'b11111111 while busy -> drop pulses once. Sequence is 6,0 only, then IDLE. The next load in IDLE is accepted normally.
6. load 8'b11110000, accept code 7, assert rst for 1 cycle mid-scan -> all outputs 0 immediately. After release out_valid stays 0 until a new load.
